trng_word_packer: RTL
=====================

// Module: trng_word_packer
// PURPOSE
//   Consumes the debiased bit stream (bit_in/bit_valid) from the von Neumann stage.
//   Runs an SP 800-90B style repetition count test (RCT) on every bit.
//   Packs accepted bits into WORD_W-bit words behind a valid/ready output register.
//   This is the last TRNG stage before the bus/consumer interface.
// PARAMETERS
//   WORD_W      32    output word width (>=8)
//   RCT_CUTOFF  32    identical consecutive bits that trip the RCT (>=2)
//   APT_WINDOW  1024  adaptive proportion window length in bits (TRNG_APT_EN only)
//   APT_CUTOFF  600   APT count that trips the test (TRNG_APT_EN only)
// PORTS
//   clk          in   1       single clock; all logic on posedge
//   rst_n        in   1       asynchronous active-low reset
//   enable       in   1       block enable; same signal that gates the entropy sources
//   bit_in       in   1       debiased random bit
//   bit_valid    in   1       bit_in is valid this cycle; no backpressure upstream
//   word_out     out  WORD_W  packed random word
//   word_valid   out  1       word_out holds an unconsumed word
//   word_ready   in   1       consumer accepts word_out when word_valid && word_ready
//   health_fail  out  1       sticky health-test alarm
//   health_clr   in   1       one-cycle pulse: clears alarm and restarts the block
//   overflow_cnt out  8       saturating count of dropped words
// BEHAVIOUR
//   Reset: word_out=0, word_valid=0, health_fail=0, overflow_cnt=0; FSM=IDLE; all counters 0.
//   FSM states:
//     IDLE: enable=0.
//     FILL: enable=1 and no alarm.
//     FAIL: alarm set.
//   FSM transitions:
//     IDLE->FILL when enable=1.
//     FILL->IDLE when enable=0; partial word and RCT run are discarded; output register is kept.
//     FILL->FAIL on an RCT/APT trip.
//     FAIL->IDLE only on health_clr. health_clr wins over a simultaneous trip.
//   Packing: LSB-first. The first accepted bit lands in word[0]. Bits are accepted only in FILL with bit_valid=1.
//   The bit that completes the word (count WORD_W-1 -> 0 wrap) moves the word into the output register.
//   word_valid rises on the next cycle.
//   Output register: held stable while word_valid && !word_ready.
//     Cleared to invalid on the handshake cycle.
//     If a handshake and a word completion occur in the same cycle, the new word is loaded and word_valid stays 1.
//   Drop: a word completes while word_valid=1 and word_ready=0. The new word is discarded, the old word is kept,
//     and overflow_cnt increments, saturating at 255.
//   RCT: tracks the last bit and the run length.
//     A new bit equal to the last bit increments the run; a different bit sets the run to 1.
//     The trip fires on the cycle the run reaches RCT_CUTOFF. The tripping bit is not packed.
//   On a trip, the next cycle has:
//     health_fail=1
//     word_valid=0 (pending word flushed, never delivered)
//     partial word discarded
//   In FAIL, input bits are ignored and word_ready has no effect.
//   health_clr: zeroes the RCT/APT state, the partial word and the bit counter.
//     Does not clear overflow_cnt; only reset clears it.
//   Reset mid-word: everything returns to reset values asynchronously. No partial word survives.
// CONFIGURATION
//   TRNG_APT_EN defined: adaptive proportion test is compiled in.
//     The first accepted bit of each APT_WINDOW-bit window is the reference.
//     A counter counts matches, including the reference bit.
//     The test trips when the counter reaches APT_CUTOFF, with the same consequences as an RCT trip.
//     The window restarts after APT_WINDOW accepted bits, and also on enable=0 and on health_clr.
//   TRNG_APT_EN undefined: no APT logic or registers exist.
//     APT_WINDOW and APT_CUTOFF are unused. Only the RCT can trip.
// STRUCTURE
//   Package trng_pkg: FSM state enum (IDLE/FILL/FAIL), default cutoff constants, overflow counter width (8).
//   Sub-module trng_rct: repetition count test with bit/valid/restart inputs and a trip pulse output.
//   Packer, output register, FSM and APT stay in this module.
// TESTING
//   1. Alternating 1010... for 64 valid bits, word_ready=1
//        -> two words of 32'h5555_5555 (bit0=1); word_valid high 1 cycle each.
//   2. 32 bits of 0x0000FFFF order with word_ready=0, then 32 more bits
//        -> first word held unchanged; overflow_cnt=1; after word_ready=1, handshake then word_valid=0.
//   3. Word completion on the same cycle as a handshake
//        -> new word loaded, word_valid stays 1, overflow_cnt unchanged.
//   4. 32 consecutive 1s (RCT_CUTOFF=32) with a pending word
//        -> health_fail=1 next cycle, word_valid=0, later bits ignored;
//           health_clr pulse -> health_fail=0, packing restarts at bit 0.
//   5. enable dropped after 10 bits, then re-raised, then 32 more bits
//        -> delivered word contains only the last 32 bits.
//   6. TRNG_APT_EN with APT_WINDOW=16, APT_CUTOFF=12: 12 ones among the first 16 bits, RCT not tripped
//        -> health_fail=1; without the macro -> no alarm.

Source files
------------

// File: rtl/trng_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : trng_pkg
// Description : Shared types and defaults for the TRNG word packer: FSM state
//               encoding, default word width / health-test cutoffs and the
//               width of the dropped-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FAIL = 2'd2
    } state_e;

    localparam int c_WORD_W_DEF     = 32;
    localparam int c_RCT_CUTOFF_DEF = 32;
    localparam int c_APT_WINDOW_DEF = 1024;
    localparam int c_APT_CUTOFF_DEF = 600;
    localparam int c_OVF_W          = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_OVF_W-1:0] sat_inc(input logic [c_OVF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trng_word_packer_if.sv
`default_nettype none
// ============================================================================
// Interface   : trng_word_packer_if
// Description : Bit-stream input and word valid/ready output of the packer.
//   bit_in/bit_valid   : debiased bit stream, no backpressure
//   word_out/word_valid: packed word, held until word_ready
//   word_ready         : consumer accept
//   modport master     : the packer (drives the word side)
//   modport slave      : the environment (drives bits and word_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface trng_word_packer_if
    import trng_pkg::*;
#(
    parameter int WORD_W = c_WORD_W_DEF
) ();
    logic              bit_in;
    logic              bit_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (
        input  bit_in,
        input  bit_valid,
        input  word_ready,
        output word_out,
        output word_valid
    );

    modport slave (
        output bit_in,
        output bit_valid,
        output word_ready,
        input  word_out,
        input  word_valid
    );
endinterface
`default_nettype wire

// File: rtl/trng_word_packer_rct.sv
`default_nettype none
// ============================================================================
// Module      : trng_rct
// Description : Repetition count test. Tracks the last accepted bit and the
//               length of the current run of identical bits; pulses trip_o
//               combinationally on the bit that brings the run to RCT_CUTOFF.
//   clk, rst_n : clock, asynchronous active-low reset
//   bit_i      : candidate bit
//   valid_i    : bit_i is accepted this cycle
//   restart_i  : discard the current run (has priority over valid_i)
//   trip_o     : run reaches RCT_CUTOFF on this accepted bit
// Revision    : 1.0 - initial release
// ============================================================================
module trng_rct #(
    parameter int RCT_CUTOFF = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_i,
    input  logic valid_i,
    input  logic restart_i,
    output logic trip_o
);
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam logic [RUN_W-1:0] c_CUTOFF = RUN_W'(RCT_CUTOFF);

    logic             last_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // After reset/restart run_q is 0, so the first bit yields a run of 1
    // whichever way the compare against last_q goes.
    always_comb begin
        run_d = RUN_W'(1);
        if (bit_i == last_q) begin
            run_d = (run_q == c_CUTOFF) ? run_q : run_q + 1'b1;
        end
    end

    assign trip_o = valid_i && !restart_i && (run_d == c_CUTOFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
            run_q  <= '0;
        end else if (restart_i) begin
            last_q <= 1'b0;
            run_q  <= '0;
        end else if (valid_i) begin
            last_q <= bit_i;
            run_q  <= run_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : trng_word_packer
// Description : Final TRNG stage. Health-tests the debiased bit stream and
//               packs accepted bits LSB-first into WORD_W-bit words behind a
//               valid/ready output register. Words completing while the
//               output is still occupied are dropped and counted.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : block enable (IDLE <-> FILL)
//   health_clr   : pulse, clears the alarm and restarts the block
//   health_fail  : sticky health-test alarm
//   overflow_cnt : saturating dropped-word count (cleared by reset only)
//   bus          : trng_word_packer_if.master (bits in, words out)
// Config macro: TRNG_APT_EN - compiles in the adaptive proportion test.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int WORD_W     = c_WORD_W_DEF,
    parameter int RCT_CUTOFF = c_RCT_CUTOFF_DEF,
    parameter int APT_WINDOW = c_APT_WINDOW_DEF,
    parameter int APT_CUTOFF = c_APT_CUTOFF_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               health_clr,
    output logic               health_fail,
    output logic [c_OVF_W-1:0] overflow_cnt,
    trng_word_packer_if.master bus
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WORD_W - 1);

    if (WORD_W < 8 || RCT_CUTOFF < 2 || APT_CUTOFF < 1 || APT_CUTOFF > APT_WINDOW) begin : g_bad_params
        $error("trng_word_packer: illegal parameter combination");
    end

    state_e             state_q;
    logic [WORD_W-1:0]  partial_q;
    logic [WORD_W-1:0]  partial_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic               valid_q;
    logic               fail_q;
    logic [c_OVF_W-1:0] ovf_q;

    logic w_accept;
    logic w_restart;
    logic w_hs;
    logic w_rct_trip;
    logic w_apt_trip;
    logic w_trip;

    // health_clr suppresses acceptance so it always wins over a trip.
    assign w_accept  = (state_q == S_FILL) && enable && bus.bit_valid && !health_clr;
    assign w_restart = (state_q != S_FILL) || !enable || health_clr;
    assign w_hs      = valid_q && bus.word_ready;
    assign w_trip    = w_rct_trip | w_apt_trip;

    always_comb begin
        partial_d        = partial_q;
        partial_d[cnt_q] = bus.bit_in;
    end

    trng_rct #(
        .RCT_CUTOFF(RCT_CUTOFF)
    ) u_rct (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_i    (bus.bit_in),
        .valid_i  (w_accept),
        .restart_i(w_restart),
        .trip_o   (w_rct_trip)
    );

`ifdef TRNG_APT_EN
    localparam int APT_W = $clog2(APT_WINDOW + 1);
    localparam logic [APT_W-1:0] c_APT_LAST = APT_W'(APT_WINDOW - 1);
    localparam logic [APT_W-1:0] c_APT_TRIP = APT_W'(APT_CUTOFF);

    logic [APT_W-1:0] apt_idx_q;
    logic [APT_W-1:0] apt_cnt_q;
    logic [APT_W-1:0] apt_cnt_d;
    logic             apt_ref_q;
    logic             w_apt_first;

    // The first bit of a window becomes the reference and counts as a match.
    assign w_apt_first = (apt_idx_q == '0);

    always_comb begin
        apt_cnt_d = apt_cnt_q;
        if (w_apt_first) begin
            apt_cnt_d = APT_W'(1);
        end else if (bus.bit_in == apt_ref_q) begin
            apt_cnt_d = apt_cnt_q + 1'b1;
        end
    end

    assign w_apt_trip = w_accept && (apt_cnt_d == c_APT_TRIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apt_idx_q <= '0;
            apt_cnt_q <= '0;
            apt_ref_q <= 1'b0;
        end else if (w_restart) begin
            apt_idx_q <= '0;
            apt_cnt_q <= '0;
            apt_ref_q <= 1'b0;
        end else if (w_accept) begin
            if (w_apt_first) begin
                apt_ref_q <= bus.bit_in;
            end
            apt_cnt_q <= apt_cnt_d;
            apt_idx_q <= (apt_idx_q == c_APT_LAST) ? '0 : apt_idx_q + 1'b1;
        end
    end
`else
    assign w_apt_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            partial_q <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            ovf_q     <= '0;
        end else if (health_clr) begin
            state_q   <= S_IDLE;
            fail_q    <= 1'b0;
            partial_q <= '0;
            cnt_q     <= '0;
            if (w_hs) begin
                valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_hs) begin
                        valid_q <= 1'b0;
                    end
                    if (enable) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!enable) begin
                        // Output register survives; only the partial word goes.
                        state_q   <= S_IDLE;
                        partial_q <= '0;
                        cnt_q     <= '0;
                        if (w_hs) begin
                            valid_q <= 1'b0;
                        end
                    end else if (w_trip) begin
                        // Pending word is flushed and never delivered.
                        state_q   <= S_FAIL;
                        fail_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        partial_q <= '0;
                        cnt_q     <= '0;
                    end else begin
                        if (w_hs) begin
                            valid_q <= 1'b0;
                        end
                        if (w_accept) begin
                            if (cnt_q == c_CNT_LAST) begin
                                partial_q <= '0;
                                cnt_q     <= '0;
                                if (valid_q && !bus.word_ready) begin
                                    ovf_q <= sat_inc(ovf_q);
                                end else begin
                                    word_q  <= partial_d;
                                    valid_q <= 1'b1;
                                end
                            end else begin
                                partial_q <= partial_d;
                                cnt_q     <= cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // S_FAIL: bits and word_ready are ignored until health_clr.
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign health_fail    = fail_q;
    assign overflow_cnt   = ovf_q;
endmodule
`default_nettype wire
